alu_sequencer: RTL and testbench

Command-driven initiator for the datapath's combinational ALU. It owns a small register file, accepts commands over a valid/ready handshake, presents opcode and operands on the ALU interface, writes the ALU result back, and returns register contents over a second valid/ready handshake. It sits between the control/test front end and the ALU instance, as the only driver of the ALU's opcode and operand inputs.

---
 rtl/alu_sequencer.sv | 110 +++++++++++
 tb/tb_alu_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer driving an external combinational ALU over an 8-entry register file.
// ALU op: 2 cycles (accept, writeback). Load: 1 per cycle. Read: held in RESP until rd_ready.
module alu_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_kind,
    input  logic [2:0]            cmd_oc,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [ADDR_WIDTH-1:0] cmd_src1,
    input  logic [ADDR_WIDTH-1:0] cmd_src2,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [2:0]            alu_oc,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_f,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err_dz
);

    localparam int         NREGS  = 2 ** ADDR_WIDTH;
    localparam logic [2:0] OC_DIV = 3'd3;
    localparam logic [1:0] K_ALU  = 2'b00;
    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_READ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   regs_q [NREGS];
    logic [ADDR_WIDTH-1:0]   dst_q;
    logic [2:0]              alu_oc_q;
    logic [DATA_WIDTH-1:0]   alu_a_q;
    logic [DATA_WIDTH-1:0]   alu_b_q;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    err_dz_q;

    assign cmd_ready = (state_q == IDLE);
    assign alu_oc    = alu_oc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign err_dz    = err_dz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dst_q      <= '0;
            alu_oc_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_dz_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            err_dz_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_kind)
                            K_ALU: begin
                                alu_oc_q <= cmd_oc;
                                alu_a_q  <= regs_q[cmd_src1];
                                alu_b_q  <= regs_q[cmd_src2];
                                dst_q    <= cmd_dst;
                                state_q  <= EXEC;
                            end
                            K_LOAD: regs_q[cmd_dst] <= cmd_imm;
                            K_READ: begin
                                rd_data_q  <= regs_q[cmd_src1];
                                rd_valid_q <= 1'b1;
                                state_q    <= RESP;
                            end
                            default: ;
                        endcase
                    end
                end
                EXEC: begin
                    // The ALU's own result is written even for a zero divisor; the flag is advisory.
                    regs_q[dst_q] <= alu_f;
                    err_dz_q      <= (alu_oc_q == OC_DIV) && (alu_b_q == '0);
                    state_q       <= IDLE;
                end
                RESP: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed table-driven bench for alu_sequencer with a behavioural ALU on the alu_* interface.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_kind;
    logic [2:0]  cmd_oc;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src1;
    logic [2:0]  cmd_src2;
    logic [15:0] cmd_imm;
    logic [2:0]  alu_oc;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_f;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        err_dz;

    int n_chk  = 0;
    int n_fail = 0;

    alu_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_oc(cmd_oc), .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .cmd_imm(cmd_imm), .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .err_dz(err_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: ADD SUB MUL DIV NOT XOR OR AND, divide by zero yields 0.
    always_comb begin
        alu_f = '0;
        case (alu_oc)
            3'd0: alu_f = alu_a + alu_b;
            3'd1: alu_f = alu_a - alu_b;
            3'd2: alu_f = alu_a * alu_b;
            3'd3: alu_f = (alu_b == 16'h0) ? 16'h0 : alu_a / alu_b;
            3'd4: alu_f = ~alu_a;
            3'd5: alu_f = alu_a ^ alu_b;
            3'd6: alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  oc;
        logic [2:0]  dst;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [15:0] imm;
        logic [15:0] exp;   // read data for reads, expected err_dz for ALU ops
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] kind, logic [2:0] oc, logic [2:0] dst,
                                logic [2:0] s1, logic [2:0] s2, logic [15:0] imm,
                                logic [15:0] exp, string name);
        vec_t v;
        v.kind = kind; v.oc = oc; v.dst = dst; v.s1 = s1; v.s2 = s2;
        v.imm = imm; v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic vec_t ld(logic [2:0] dst, logic [15:0] imm);
        return mk(2'b01, 3'd0, dst, 3'd0, 3'd0, imm, 16'h0, "load");
    endfunction

    function automatic vec_t op(logic [2:0] oc, logic [2:0] dst, logic [2:0] s1,
                                logic [2:0] s2, logic dz, string name);
        return mk(2'b00, oc, dst, s1, s2, 16'h0, {15'h0, dz}, name);
    endfunction

    function automatic vec_t rd(logic [2:0] s1, logic [15:0] exp, string name);
        return mk(2'b10, 3'd0, 3'd0, s1, 3'd0, 16'h0, exp, name);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [1:0] kind, logic [2:0] oc, logic [2:0] dst,
                        logic [2:0] s1, logic [2:0] s2, logic [15:0] imm);
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", {31'h0, cmd_ready}, 32'h1);
        cmd_kind = kind; cmd_oc = oc; cmd_dst = dst;
        cmd_src1 = s1; cmd_src2 = s2; cmd_imm = imm;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic apply(vec_t v);
        send(v.kind, v.oc, v.dst, v.s1, v.s2, v.imm);
        case (v.kind)
            2'b00: begin
                chk({v.name, "_busy"}, {31'h0, cmd_ready}, 32'h0);
                step();
                chk({v.name, "_ready"}, {31'h0, cmd_ready}, 32'h1);
                chk({v.name, "_err_dz"}, {31'h0, err_dz}, {16'h0, v.exp});
            end
            2'b01: chk({v.name, "_ready"}, {31'h0, cmd_ready}, 32'h1);
            2'b10: begin
                chk({v.name, "_rd_valid"}, {31'h0, rd_valid}, 32'h1);
                chk({v.name, "_rd_data"}, {16'h0, rd_data}, {16'h0, v.exp});
                chk({v.name, "_err_dz_clr"}, {31'h0, err_dz}, 32'h0);
                step();
                chk({v.name, "_rd_done"}, {31'h0, rd_valid}, 32'h0);
                chk({v.name, "_ready"}, {31'h0, cmd_ready}, 32'h1);
            end
            default: begin
                chk({v.name, "_ready"}, {31'h0, cmd_ready}, 32'h1);
                chk({v.name, "_no_rd"}, {31'h0, rd_valid}, 32'h0);
            end
        endcase
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rd_ready = 1'b1;
        cmd_kind = '0; cmd_oc = '0; cmd_dst = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_imm = '0;

        // Table: reset contents, arithmetic, zero-divisor, reserved kind, in-place ops.
        for (int i = 0; i < 8; i++) tbl.push_back(rd(3'(i), 16'h0000, "rst_reg"));
        tbl.push_back(ld(3'd1, 16'h0003));
        tbl.push_back(ld(3'd2, 16'h0005));
        tbl.push_back(op(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, "add"));
        tbl.push_back(op(3'd1, 3'd4, 3'd1, 3'd2, 1'b0, "sub"));
        tbl.push_back(rd(3'd3, 16'h0008, "rd_add"));
        tbl.push_back(rd(3'd4, 16'hFFFE, "rd_sub"));
        tbl.push_back(ld(3'd1, 16'h0100));
        tbl.push_back(op(3'd2, 3'd5, 3'd1, 3'd1, 1'b0, "mul"));
        tbl.push_back(rd(3'd5, 16'h0000, "rd_mul"));
        tbl.push_back(op(3'd3, 3'd6, 3'd1, 3'd0, 1'b1, "div0"));
        tbl.push_back(rd(3'd6, 16'h0000, "rd_div0"));
        tbl.push_back(op(3'd3, 3'd6, 3'd1, 3'd1, 1'b0, "div"));
        tbl.push_back(rd(3'd6, 16'h0001, "rd_div"));
        tbl.push_back(mk(2'b11, 3'd0, 3'd1, 3'd0, 3'd0, 16'hDEAD, 16'h0, "rsvd"));
        tbl.push_back(rd(3'd1, 16'h0100, "rd_rsvd"));
        tbl.push_back(ld(3'd1, 16'h00F0));
        tbl.push_back(ld(3'd2, 16'h0F0F));
        tbl.push_back(op(3'd5, 3'd1, 3'd1, 3'd2, 1'b0, "xor"));
        tbl.push_back(op(3'd7, 3'd2, 3'd1, 3'd2, 1'b0, "and"));
        tbl.push_back(rd(3'd1, 16'h0FFF, "rd_xor"));
        tbl.push_back(rd(3'd2, 16'h0F0F, "rd_and"));
        tbl.push_back(op(3'd6, 3'd3, 3'd1, 3'd2, 1'b0, "or"));
        tbl.push_back(op(3'd4, 3'd4, 3'd1, 3'd0, 1'b0, "not"));
        tbl.push_back(rd(3'd3, 16'h0FFF, "rd_or"));
        tbl.push_back(rd(3'd4, 16'hF000, "rd_not"));

        // Reset values while held in reset.
        #12;
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_err_dz", {31'h0, err_dz}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Dirty every output, then assert reset mid-cycle inside a stalled read.
        send(2'b01, 3'd0, 3'd7, 3'd0, 3'd0, 16'h1234);
        send(2'b00, 3'd0, 3'd7, 3'd7, 3'd7, 16'h0);
        step();
        rd_ready = 1'b0;
        send(2'b10, 3'd0, 3'd0, 3'd7, 3'd0, 16'h0);
        chk("pre_rst_rd_data", {16'h0, rd_data}, 32'h2468);
        chk("pre_rst_alu_a", {16'h0, alu_a}, 32'h1234);
        #3 rst_n = 1'b0;
        #1;
        chk("async_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("async_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("async_rd_data", {16'h0, rd_data}, 32'h0);
        chk("async_alu_oc", {29'h0, alu_oc}, 32'h0);
        chk("async_alu_a", {16'h0, alu_a}, 32'h0);
        chk("async_alu_b", {16'h0, alu_b}, 32'h0);
        chk("async_err_dz", {31'h0, err_dz}, 32'h0);
        step();
        rst_n = 1'b1;
        rd_ready = 1'b1;
        step();

        foreach (tbl[i]) apply(tbl[i]);

        // Stalled read: outputs held, queued command ignored.
        send(2'b01, 3'd0, 3'd3, 3'd0, 3'd0, 16'h0008);
        rd_ready = 1'b0;
        send(2'b10, 3'd0, 3'd0, 3'd3, 3'd0, 16'h0);
        cmd_kind = 2'b01; cmd_dst = 3'd0; cmd_imm = 16'hBEEF; cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_rd_valid", {31'h0, rd_valid}, 32'h1);
            chk("stall_rd_data", {16'h0, rd_data}, 32'h0008);
            chk("stall_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            step();
        end
        cmd_valid = 1'b0;
        rd_ready = 1'b1;
        chk("stall_hold_last", {16'h0, rd_data}, 32'h0008);
        step();
        chk("stall_released", {31'h0, rd_valid}, 32'h0);
        chk("stall_idle", {31'h0, cmd_ready}, 32'h1);
        apply(rd(3'd0, 16'h0000, "rd_queued_dropped"));

        // Reset during EXEC of ADD r7: no writeback.
        send(2'b01, 3'd0, 3'd1, 3'd0, 3'd0, 16'h0003);
        send(2'b01, 3'd0, 3'd2, 3'd0, 3'd0, 16'h0005);
        send(2'b00, 3'd0, 3'd7, 3'd1, 3'd2, 16'h0);
        chk("exec_busy", {31'h0, cmd_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("exec_rst_ready", {31'h0, cmd_ready}, 32'h1);
        step();
        chk("exec_rst_err_dz", {31'h0, err_dz}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("exec_rst_idle", {31'h0, cmd_ready}, 32'h1);
        apply(rd(3'd7, 16'h0000, "rd_r7_aborted"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
